sd_emmc_axi_mem_responder: RTL and testbench

AXI4 slave memory that answers the M_AXI side of the SD/eMMC host DMA engine. It serves the engine's single-beat writes (card-to-host transfers) and its 16-beat incrementing read bursts (host-to-card transfers). It backs a word-addressed on-chip RAM window and acts as the DMA system-memory target in block-level simulation and in standalone FPGA bring-up. Read and write channels are independent, with one outstanding transaction per direction.

---
 rtl/sd_emmc_axi_mem_responder_if.sv | 37 +++
 rtl/sd_emmc_axi_mem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_sd_emmc_axi_mem_responder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_emmc_axi_mem_responder_if.sv
// AXI4 write/read channel bundle between the SD/eMMC DMA master and its
// system-memory responder (fixed 4-byte INCR transfers).
interface sd_emmc_axi_mem_responder_if;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/sd_emmc_axi_mem_responder.sv
// AXI4 slave RAM window serving the SD/eMMC DMA engine: independent write and
// read FSMs, one outstanding transaction each, SLVERR for beats outside the window.
module sd_emmc_axi_mem_responder #(
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sd_emmc_axi_mem_responder_if.slave   axi
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  localparam int DEPTH = 1 << MEM_AW;

  logic [31:0] mem_r [0:DEPTH-1];

  wstate_t     wstate_r;
  logic [31:0] waddr_r;
  logic [7:0]  wlen_r;
  logic [7:0]  wcnt_r;
  logic        werr_r;
  logic        awready_r;
  logic        wready_r;
  logic        bvalid_r;
  logic [1:0]  bresp_r;

  rstate_t     rstate_r;
  logic [31:0] raddr_r;
  logic [7:0]  rlen_r;
  logic [7:0]  rcnt_r;
  logic        arready_r;
  logic        rvalid_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic        rlast_r;

  logic        w_fire_s;
  logic        w_in_win_s;
  logic        w_last_beat_s;
  logic        w_err_next_s;
  logic [MEM_AW-1:0] w_idx_s;

  logic [31:0] r_load_addr_s;
  logic [31:0] r_load_data_s;
  logic [1:0]  r_load_resp_s;
  logic [MEM_AW-1:0] r_idx_s;

  logic        unused_addr_bits_s;

  function automatic logic in_window(input logic [31:0] addr);
    return addr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2];
  endfunction

  assign axi.awready = awready_r;
  assign axi.wready  = wready_r;
  assign axi.bvalid  = bvalid_r;
  assign axi.bresp   = bresp_r;
  assign axi.arready = arready_r;
  assign axi.rvalid  = rvalid_r;
  assign axi.rdata   = rdata_r;
  assign axi.rresp   = rresp_r;
  assign axi.rlast   = rlast_r;

  assign unused_addr_bits_s = ^{axi.awaddr[1:0], axi.araddr[1:0], waddr_r[1:0], raddr_r[1:0]};

  // Write-beat decode: acceptance, window check, last-beat and error accumulation
  always_comb begin
    w_fire_s      = 1'b0;
    w_in_win_s    = 1'b0;
    w_last_beat_s = 1'b0;
    w_err_next_s  = werr_r;
    w_idx_s       = waddr_r[MEM_AW+1:2];
    if (wstate_r == W_DATA) begin
      w_fire_s      = axi.wvalid & wready_r;
      w_in_win_s    = in_window(waddr_r);
      w_last_beat_s = (wcnt_r == wlen_r);
      w_err_next_s  = werr_r | ~w_in_win_s | (axi.wlast != w_last_beat_s);
    end else begin
      w_fire_s = 1'b0;
    end
  end

  // Read-beat fetch: beat 0 comes from araddr, later beats from the advanced address
  always_comb begin
    r_load_addr_s = raddr_r + 32'd4;
    r_load_data_s = 32'h0000_0000;
    r_load_resp_s = 2'b10;
    if (rstate_r == R_IDLE) begin
      r_load_addr_s = axi.araddr;
    end else begin
      r_load_addr_s = raddr_r + 32'd4;
    end
    r_idx_s = r_load_addr_s[MEM_AW+1:2];
    if (in_window(r_load_addr_s)) begin
      r_load_data_s = mem_r[r_idx_s];
      r_load_resp_s = 2'b00;
    end else begin
      r_load_data_s = 32'h0000_0000;
      r_load_resp_s = 2'b10;
    end
  end

  // Byte-enabled RAM write port; contents are deliberately kept across reset
  always_ff @(posedge clk) begin
    if (w_fire_s && w_in_win_s) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.wstrb[b]) begin
          mem_r[w_idx_s][8*b +: 8] <= axi.wdata[8*b +: 8];
        end
      end
    end
  end

  // Write FSM with registered AW/W/B handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_r  <= W_IDLE;
      waddr_r   <= 32'h0000_0000;
      wlen_r    <= 8'd0;
      wcnt_r    <= 8'd0;
      werr_r    <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      case (wstate_r)
        W_IDLE: begin
          awready_r <= 1'b1;
          if (axi.awvalid && awready_r) begin
            waddr_r   <= axi.awaddr;
            wlen_r    <= axi.awlen;
            wcnt_r    <= 8'd0;
            werr_r    <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            wstate_r  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_s) begin
            waddr_r <= waddr_r + 32'd4;
            wcnt_r  <= wcnt_r + 8'd1;
            werr_r  <= w_err_next_s;
            if (w_last_beat_s) begin
              wready_r <= 1'b0;
              bvalid_r <= 1'b1;
              bresp_r  <= w_err_next_s ? 2'b10 : 2'b00;
              wstate_r <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            awready_r <= 1'b1;
            wstate_r  <= W_IDLE;
          end
        end
        default: begin
          wstate_r  <= W_IDLE;
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          bresp_r   <= 2'b00;
        end
      endcase
    end
  end

  // Read FSM; the next beat is registered on the same edge that retires the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_r  <= R_IDLE;
      raddr_r   <= 32'h0000_0000;
      rlen_r    <= 8'd0;
      rcnt_r    <= 8'd0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      rresp_r   <= 2'b00;
      rlast_r   <= 1'b0;
    end else begin
      case (rstate_r)
        R_IDLE: begin
          arready_r <= 1'b1;
          if (axi.arvalid && arready_r) begin
            raddr_r   <= axi.araddr;
            rlen_r    <= axi.arlen;
            rcnt_r    <= 8'd0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= r_load_data_s;
            rresp_r   <= r_load_resp_s;
            rlast_r   <= (axi.arlen == 8'd0);
            rstate_r  <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi.rready) begin
            if (rcnt_r == rlen_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              rstate_r  <= R_IDLE;
            end else begin
              raddr_r <= r_load_addr_s;
              rcnt_r  <= rcnt_r + 8'd1;
              rdata_r <= r_load_data_s;
              rresp_r <= r_load_resp_s;
              rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
            end
          end
        end
        default: begin
          rstate_r  <= R_IDLE;
          arready_r <= 1'b0;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_emmc_axi_mem_responder.sv
// Randomised self-checking bench for sd_emmc_axi_mem_responder against a
// word-map memory model (default 16 KB window at address 0).
module tb_sd_emmc_axi_mem_responder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] model [logic [31:0]];

  sd_emmc_axi_mem_responder_if bus ();

  sd_emmc_axi_mem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] a);
    return a < 32'h0000_4000;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int beats, input logic [31:0] d0,
                           input logic [3:0] strb, input bit bad_last);
    logic [1:0]  exp_resp;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] m;
    int n;
    exp_resp = bad_last ? 2'b10 : 2'b00;
    bus.awaddr  = addr;
    bus.awlen   = 8'(beats - 1);
    bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (bus.awready !== 1'b1) begin
      bad++; $display("FAIL aw_wait addr=%h awready=%b required 1", addr, bus.awready);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    total++;
    if (bus.wready !== 1'b1) begin
      bad++; $display("FAIL wready_after_aw addr=%h got %b required 1", addr, bus.wready);
    end
    for (int i = 0; i < beats; i++) begin
      a = addr + 32'(4 * i);
      d = d0 + 32'(i);
      bus.wvalid = 1'b1;
      bus.wdata  = d;
      bus.wstrb  = strb;
      bus.wlast  = (i == beats - 1) ^ (bad_last && i == 0);
      @(posedge clk); #1;
      if (in_win(a)) begin
        if (model.exists(a >> 2) || strb == 4'hF) begin
          m = model.exists(a >> 2) ? model[a >> 2] : 32'h0000_0000;
          for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = d[8*b +: 8];
          model[a >> 2] = m;
        end
      end else begin
        exp_resp = 2'b10;
      end
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    total++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== exp_resp) begin
      bad++; $display("FAIL bresp addr=%h got bvalid=%b bresp=%b required 1/%b",
                      addr, bus.bvalid, bus.bresp, exp_resp);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    total++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
      bad++; $display("FAIL b_done addr=%h got bvalid=%b awready=%b required 0/1",
                      addr, bus.bvalid, bus.awready);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int beats, input bit pulsed,
                          input int abort_after);
    logic [31:0] a;
    logic [31:0] ed;
    logic [1:0]  er;
    bit known;
    bit rr;
    int n;
    int beat;
    int cyc;
    bus.araddr  = addr;
    bus.arlen   = 8'(beats - 1);
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (bus.arready !== 1'b1) begin
      bad++; $display("FAIL ar_wait addr=%h arready=%b required 1", addr, bus.arready);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    total++;
    if (bus.rvalid !== 1'b1) begin
      bad++; $display("FAIL rvalid_after_ar addr=%h got %b required 1", addr, bus.rvalid);
    end
    beat = 0;
    cyc  = 0;
    while (beat < beats && cyc < 100 && beat != abort_after) begin
      rr = pulsed ? (cyc % 3 == 2) : 1'b1;
      bus.rready = rr;
      a = addr + 32'(4 * beat);
      if (in_win(a)) begin
        er    = 2'b00;
        known = model.exists(a >> 2);
        ed    = known ? model[a >> 2] : 32'h0000_0000;
      end else begin
        er    = 2'b10;
        known = 1'b1;
        ed    = 32'h0000_0000;
      end
      total++;
      if (bus.rvalid !== 1'b1 || bus.rresp !== er || bus.rlast !== (beat == beats - 1) ||
          (known && bus.rdata !== ed)) begin
        bad++;
        $display("FAIL r_beat addr=%h beat=%0d got v=%b d=%h resp=%b last=%b required 1/%h/%b/%b",
                 addr, beat, bus.rvalid, bus.rdata, bus.rresp, bus.rlast, ed, er, beat == beats - 1);
      end
      @(posedge clk); #1;
      if (rr) beat++;
      cyc++;
    end
    bus.rready = 1'b0;
    if (abort_after < 0) begin
      total++;
      if (beat != beats || bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
        bad++; $display("FAIL r_done addr=%h beats=%0d/%0d rvalid=%b arready=%b required 0/1",
                        addr, beat, beats, bus.rvalid, bus.arready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.awaddr = 32'h0; bus.awlen = 8'h0; bus.awvalid = 1'b0;
    bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = 32'h0; bus.arlen = 8'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid,
         bus.rdata, bus.rresp, bus.rlast} !== 41'h0) begin
      bad++; $display("FAIL reset_values aw=%b w=%b b=%b br=%b ar=%b rv=%b rd=%h rr=%b rl=%b required all 0",
                      bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid,
                      bus.rdata, bus.rresp, bus.rlast);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.awready !== 1'b0 || bus.arready !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge aw=%b ar=%b required 0/0", bus.awready, bus.arready);
    end
    @(posedge clk); #1;
    total++;
    if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
      bad++; $display("FAIL ready_after_edge aw=%b ar=%b required 1/1", bus.awready, bus.arready);
    end
  endtask

  task automatic test_single();
    axi_write(32'h0000_0040, 1, 32'hDEAD_BEEF, 4'hF, 1'b0);
    axi_read(32'h0000_0040, 1, 1'b0, -1);
  endtask

  task automatic test_dma_writes();
    for (int i = 0; i < 128; i++) axi_write(32'h0000_1000 + 32'(4 * i), 1, $urandom, 4'hF, 1'b0);
    axi_read(32'h0000_1000, 16, 1'b0, -1);
  endtask

  task automatic test_pulsed_rready();
    axi_read(32'h0000_1040, 16, 1'b1, -1);
  endtask

  task automatic test_strobes();
    axi_write(32'h0000_0200, 1, 32'hFFFF_FFFF, 4'hF, 1'b0);
    axi_write(32'h0000_0200, 1, 32'h1122_3344, 4'b0101, 1'b0);
    axi_read(32'h0000_0200, 1, 1'b0, -1);
  endtask

  task automatic test_window_edge();
    axi_write(32'h0000_3FF8, 2, $urandom, 4'hF, 1'b0);
    axi_write(32'h0000_0000, 1, 32'hA5A5_0001, 4'hF, 1'b0);
    axi_write(32'h0000_4000, 1, 32'h1234_5678, 4'hF, 1'b0);
    axi_read(32'h0000_3FF8, 4, 1'b0, -1);
    axi_read(32'h0000_0000, 1, 1'b0, -1);
  endtask

  task automatic test_wlast_error();
    axi_write(32'h0000_0300, 2, $urandom, 4'hF, 1'b1);
    axi_write(32'h0000_0310, 1, $urandom, 4'hF, 1'b1);
    axi_read(32'h0000_0300, 2, 1'b0, -1);
  endtask

  task automatic test_reset_mid_read();
    axi_read(32'h0000_1000, 16, 1'b0, 6);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
      bad++; $display("FAIL mid_reset rvalid=%b arready=%b required 0/0", bus.rvalid, bus.arready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin
      bad++; $display("FAIL after_mid_reset arready=%b awready=%b required 1/1", bus.arready, bus.awready);
    end
    axi_read(32'h0000_1000, 16, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 24; i++) begin
      a = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      axi_write(a, 1, $urandom, 4'hF, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      a = {18'd0, 12'($urandom_range(4080, 4095)), 2'b00};
      axi_read(a, $urandom_range(1, 16), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_dma_writes();
    test_pulsed_rready();
    test_strobes();
    test_window_edge();
    test_wlast_error();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
